// File: rtl/vga_timing_gen.sv
// VGA pixel-timing generator: clock divider, horizontal/vertical counters and registered
// sync/blanking decode. Define VGA_FRAME_CNT_EN to add the 8-bit frame_cnt output.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter int unsigned SYNC_POL  = 0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
`ifdef VGA_FRAME_CNT_EN
    output logic [7:0] frame_cnt,
`endif
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_MAX     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS     = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS     = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START  = 10'(H_DISPLAY + H_FP);
    localparam logic [9:0] HS_END    = 10'(H_DISPLAY + H_FP + H_SYNC);
    localparam logic [9:0] VS_START  = 10'(V_DISPLAY + V_FP);
    localparam logic [9:0] VS_END    = 10'(V_DISPLAY + V_FP + V_SYNC);
    localparam int unsigned DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic SYNC_ACT = (SYNC_POL != 0);

    logic [DIV_W-1:0] div_cnt;
    logic [9:0]       x_next;
    logic [9:0]       y_next;
    logic             x_end;
    logic             y_end;
    logic             hsync_next;
    logic             vsync_next;
    logic             video_on_next;

    // Out-of-range counts (>= TOTAL) are treated as the last position so they wrap to 0.
    always_comb begin
        x_end  = (x >= H_MAX);
        y_end  = (y >= V_MAX);
        x_next = x_end ? 10'd0 : x + 10'd1;
        y_next = y;
        if (x_end) begin
            y_next = y_end ? 10'd0 : y + 10'd1;
        end
        hsync_next    = ((x_next >= HS_START) && (x_next < HS_END)) ? SYNC_ACT : ~SYNC_ACT;
        vsync_next    = ((y_next >= VS_START) && (y_next < VS_END)) ? SYNC_ACT : ~SYNC_ACT;
        video_on_next = (x_next < H_VIS) && (y_next < V_VIS);
    end

    assign p_tick      = (div_cnt == DIV_MAX);
    assign frame_start = p_tick && (x == 10'd0) && (y == 10'd0);

    // Decodes are taken from the next counts so they line up with x/y on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt  <= '0;
            x        <= 10'd0;
            y        <= 10'd0;
            hsync    <= ~SYNC_ACT;
            vsync    <= ~SYNC_ACT;
            video_on <= 1'b0;
        end else begin
            div_cnt <= p_tick ? '0 : div_cnt + DIV_W'(1);
            if (p_tick) begin
                x        <= x_next;
                y        <= y_next;
                hsync    <= hsync_next;
                vsync    <= vsync_next;
                video_on <= video_on_next;
            end
        end
    end

`ifdef VGA_FRAME_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= 8'd0;
        end else if (p_tick && (x == H_MAX) && (y == V_MAX)) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: default-timing instance (a) against a constant table,
// small-timing SYNC_POL=1/CLK_DIV=2 instance (b) against a tick-count model via a scoreboard.
module tb_vga_timing_gen;

    localparam int BDIV = 2;
    localparam int BHD = 8;
    localparam int BHF = 2;
    localparam int BHS = 3;
    localparam int BHB = 2;
    localparam int BVD = 6;
    localparam int BVF = 1;
    localparam int BVS = 2;
    localparam int BVB = 1;
    localparam int BHT = BHD + BHF + BHS + BHB;
    localparam int BVT = BVD + BVF + BVS + BVB;
    localparam int BFRAME = BHT * BVT * BDIV;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a, reset_b;
    logic       p_tick_a, hsync_a, vsync_a, video_on_a, frame_start_a;
    logic       p_tick_b, hsync_b, vsync_b, video_on_b, frame_start_b;
    logic [9:0] x_a, y_a, x_b, y_b;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt_a, frame_cnt_b;
`endif

    vga_timing_gen dut_a (
        .clk         (clk),
        .reset       (reset_a),
        .p_tick      (p_tick_a),
        .x           (x_a),
        .y           (y_a),
        .hsync       (hsync_a),
        .vsync       (vsync_a),
        .video_on    (video_on_a),
`ifdef VGA_FRAME_CNT_EN
        .frame_cnt   (frame_cnt_a),
`endif
        .frame_start (frame_start_a)
    );

    vga_timing_gen #(
        .CLK_DIV   (BDIV),
        .H_DISPLAY (BHD),
        .H_FP      (BHF),
        .H_SYNC    (BHS),
        .H_BP      (BHB),
        .V_DISPLAY (BVD),
        .V_FP      (BVF),
        .V_SYNC    (BVS),
        .V_BP      (BVB),
        .SYNC_POL  (1)
    ) dut_b (
        .clk         (clk),
        .reset       (reset_b),
        .p_tick      (p_tick_b),
        .x           (x_b),
        .y           (y_b),
        .hsync       (hsync_b),
        .vsync       (vsync_b),
        .video_on    (video_on_b),
`ifdef VGA_FRAME_CNT_EN
        .frame_cnt   (frame_cnt_b),
`endif
        .frame_start (frame_start_b)
    );

    typedef struct packed {
        logic       p_tick;
        logic [9:0] x;
        logic [9:0] y;
        logic       hsync;
        logic       vsync;
        logic       video_on;
        logic       frame_start;
        logic [7:0] frame_cnt;
    } vec_t;

    typedef struct {
        int   c;
        vec_t v;
    } entry_t;

    typedef struct {
        bit   is_b;
        int   c;
        vec_t v;
    } sb_t;

    entry_t tbl[$];
    sb_t    sbq[$];
    int     n_checks = 0;
    int     n_fail = 0;
    int     ca = 0;
    int     cb = 0;
    int     ti = 0;
    bit     a_live = 0;
    bit     b_live = 0;
    bit     b_full = 0;

    function automatic entry_t mk(int c, bit p, int xv, int yv, bit hs, bit vs, bit vo, bit fs);
        entry_t e;
        e.c = c;
        e.v.p_tick = p;
        e.v.x = 10'(xv);
        e.v.y = 10'(yv);
        e.v.hsync = hs;
        e.v.vsync = vs;
        e.v.video_on = vo;
        e.v.frame_start = fs;
        e.v.frame_cnt = 8'd0;
        return e;
    endfunction

    // Expected instance-b outputs after c clock edges since reset release.
    function automatic vec_t model_b(int c);
        vec_t v;
        int n, xv, yv;
        n  = c / BDIV;
        xv = n % BHT;
        yv = (n / BHT) % BVT;
        v.p_tick = ((c % BDIV) == BDIV - 1);
        v.x = 10'(xv);
        v.y = 10'(yv);
        v.hsync = (xv >= BHD + BHF) && (xv < BHD + BHF + BHS);
        v.vsync = (yv >= BVD + BVF) && (yv < BVD + BVF + BVS);
        v.video_on = (n > 0) && (xv < BHD) && (yv < BVD);
        v.frame_start = v.p_tick && (xv == 0) && (yv == 0);
        v.frame_cnt = 8'((n / (BHT * BVT)) % 256);
        return v;
    endfunction

    function automatic vec_t sample(bit is_b);
        vec_t s;
        s.p_tick      = is_b ? p_tick_b : p_tick_a;
        s.x           = is_b ? x_b : x_a;
        s.y           = is_b ? y_b : y_a;
        s.hsync       = is_b ? hsync_b : hsync_a;
        s.vsync       = is_b ? vsync_b : vsync_a;
        s.video_on    = is_b ? video_on_b : video_on_a;
        s.frame_start = is_b ? frame_start_b : frame_start_a;
`ifdef VGA_FRAME_CNT_EN
        s.frame_cnt   = is_b ? frame_cnt_b : frame_cnt_a;
`else
        s.frame_cnt   = 8'd0;
`endif
        return s;
    endfunction

    task automatic check(string name, int c, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at clk %0d: got %0d, expected %0d", name, c, act, exp);
        end
    endtask

    task automatic compare(sb_t e);
        vec_t  a;
        string d;
        a = sample(e.is_b);
        d = e.is_b ? "b." : "a.";
        check({d, "p_tick"}, e.c, 32'(a.p_tick), 32'(e.v.p_tick));
        check({d, "x"}, e.c, 32'(a.x), 32'(e.v.x));
        check({d, "y"}, e.c, 32'(a.y), 32'(e.v.y));
        check({d, "hsync"}, e.c, 32'(a.hsync), 32'(e.v.hsync));
        check({d, "vsync"}, e.c, 32'(a.vsync), 32'(e.v.vsync));
        check({d, "video_on"}, e.c, 32'(a.video_on), 32'(e.v.video_on));
        check({d, "frame_start"}, e.c, 32'(a.frame_start), 32'(e.v.frame_start));
`ifdef VGA_FRAME_CNT_EN
        check({d, "frame_cnt"}, e.c, 32'(a.frame_cnt), 32'(e.v.frame_cnt));
`endif
    endtask

    function automatic bit b_point(int c);
        int m;
        m = c % BFRAME;
        return (m <= 1) || (m == BFRAME - 1);
    endfunction

    task automatic enqueue();
        if (a_live && ti < tbl.size() && tbl[ti].c == ca) begin
            sbq.push_back('{is_b: 1'b0, c: ca, v: tbl[ti].v});
            ti++;
        end
        if (b_live && (b_full || b_point(cb))) begin
            sbq.push_back('{is_b: 1'b1, c: cb, v: model_b(cb)});
        end
    endtask

    task automatic drain();
        sb_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            compare(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (a_live) ca++;
        if (b_live) cb++;
        enqueue();
        @(negedge clk);
        drain();
    endtask

    initial begin
        vec_t m;
        reset_a = 1'b1;
        reset_b = 1'b1;
        //           c     p  x    y  hs vs vo fs
        tbl.push_back(mk(0,    0, 0,   0, 1, 1, 0, 0));
        tbl.push_back(mk(1,    0, 0,   0, 1, 1, 0, 0));
        tbl.push_back(mk(2,    0, 0,   0, 1, 1, 0, 0));
        tbl.push_back(mk(3,    1, 0,   0, 1, 1, 0, 1));
        tbl.push_back(mk(4,    0, 1,   0, 1, 1, 1, 0));
        tbl.push_back(mk(7,    1, 1,   0, 1, 1, 1, 0));
        tbl.push_back(mk(8,    0, 2,   0, 1, 1, 1, 0));
        tbl.push_back(mk(11,   1, 2,   0, 1, 1, 1, 0));
        tbl.push_back(mk(2559, 1, 639, 0, 1, 1, 1, 0));
        tbl.push_back(mk(2560, 0, 640, 0, 1, 1, 0, 0));
        tbl.push_back(mk(2623, 1, 655, 0, 1, 1, 0, 0));
        tbl.push_back(mk(2624, 0, 656, 0, 0, 1, 0, 0));
        tbl.push_back(mk(3007, 1, 751, 0, 0, 1, 0, 0));
        tbl.push_back(mk(3008, 0, 752, 0, 1, 1, 0, 0));
        tbl.push_back(mk(3199, 1, 799, 0, 1, 1, 0, 0));
        tbl.push_back(mk(3200, 0, 0,   1, 1, 1, 1, 0));
        tbl.push_back(mk(3203, 1, 0,   1, 1, 1, 1, 0));

        repeat (5) @(posedge clk);
        @(negedge clk);
        // Reset-held state of both instances
        sbq.push_back('{is_b: 1'b0, c: 0, v: tbl[0].v});
        sbq.push_back('{is_b: 1'b1, c: 0, v: model_b(0)});
        drain();

        // Default-timing instance: one full line plus the start of the next
        reset_a = 1'b0;
        a_live  = 1'b1;
        enqueue();
        drain();
        while (ti < tbl.size()) step();

        // Small-timing instance: two frames every clock, then frame boundaries up to wrap 257
        reset_b = 1'b0;
        b_live  = 1'b1;
        b_full  = 1'b1;
        cb      = 0;
        enqueue();
        drain();
        while (cb < 2 * BFRAME) step();
        b_full = 1'b0;
        while (cb < 257 * BFRAME + 1) step();

        // Reset mid-frame with both syncs active
        m = model_b(cb);
        while (!(m.x == 10'd12 && m.y == 10'd8)) begin
            step();
            m = model_b(cb);
        end
        sbq.push_back('{is_b: 1'b1, c: cb, v: m});
        drain();
        #2 reset_b = 1'b1;
        #1;
        sbq.push_back('{is_b: 1'b1, c: 0, v: model_b(0)});
        drain();
        b_live = 1'b0;
        step();
        step();
        reset_b = 1'b0;
        cb      = 0;
        b_live  = 1'b1;
        b_full  = 1'b1;
        enqueue();
        drain();
        while (cb < 80) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Pixel-timing generator for the 640x480@60 Hz VGA path; sits directly upstream of the RGB output register stage and drives its hsync, vsync, video_on and pixel coordinates. Divides the 100 MHz system clock into a 25 MHz pixel-enable pulse, then runs the horizontal and vertical counters from that pulse. Decodes sync, blanking and frame-boundary strobes from the counters. Consumers use x/y for pixel generation and gate RGB with video_on.

Parameters:
CLK_DIV, 4, system clocks per pixel tick (>=2)
H_DISPLAY, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_DISPLAY, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, sync active level (0 = active-low)

Ports:
clk  input  1  system clock, 100 MHz
reset  input  1  asynchronous, active-high
p_tick  output  1  pixel-enable pulse, one clk wide, every CLK_DIV clocks
x  output  10  horizontal count, 0..H_TOTAL-1
y  output  10  vertical count, 0..V_TOTAL-1
hsync  output  1  horizontal sync, polarity per SYNC_POL
vsync  output  1  vertical sync, polarity per SYNC_POL
video_on  output  1  high when x<H_DISPLAY and y<V_DISPLAY
frame_start  output  1  one-clk pulse on the tick presenting pixel (0,0)

Behaviour:
- Derived: H_TOTAL = H_DISPLAY+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_DISPLAY+V_FP+V_SYNC+V_BP (525).
- Reset (async, active-high): div counter=0, x=0, y=0, hsync=vsync=~SYNC_POL (inactive), video_on=0, frame_start=0, p_tick=0.
- Divider: div_cnt counts 0..CLK_DIV-1, wraps. p_tick = (div_cnt==CLK_DIV-1), decoded from the register. After reset release, p_tick is first high in the 4th clock (CLK_DIV=4), then every 4th clock.
- Counters change only on a clk edge where p_tick=1. x increments; at x=H_TOTAL-1, x->0 and y increments; at y=V_TOTAL-1 with x=H_TOTAL-1, both ->0.
- hsync, vsync, video_on are registered, computed from next-count values, so they change on the same edge as x/y and always describe the current x/y. Zero added latency relative to x/y.
- hsync active for H_DISPLAY+H_FP <= x < H_DISPLAY+H_FP+H_SYNC (656..751). vsync active for 490 <= y <= 491.
- video_on: high for x<640 and y<480. Forced low from reset until the first p_tick edge, even though x=y=0.
- frame_start = p_tick AND x==0 AND y==0. Combinational from registers. Fires on the first tick after reset, then once per 420000 ticks.
- All compares are unsigned at 10-bit width. Counters never exceed TOTAL-1; any value >=TOTAL (illegal) wraps to 0 on the next tick.
- Reset asserted mid-frame: immediate return to reset values; no partial sync pulse persists.

Optional Feature:
Macro VGA_FRAME_CNT_EN.
- Defined: adds output frame_cnt [7:0]. Reset 0. Increments by 1 on the tick edge where (x,y) wraps from (799,524) to (0,0). Wraps 255->0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset held 5 clks, then released -> x=0, y=0, hsync=vsync=1, video_on=0; p_tick high on clocks 4,8,12,... after release; frame_start high on clock 4 only.
- Run one line -> x reaches 799 then 0 with y=1; hsync low exactly for x=656..751 (96 ticks, 384 clks); video_on low for x>=640.
- Run full frame -> vsync low exactly for y=490..491 (1600 ticks); video_on low for all y>=480; at (799,524) the next tick gives (0,0) and frame_start=1.
- Assert reset at x=700, y=491 (hsync and vsync active) -> same clock, hsync=vsync=1, x=y=0, video_on=0; normal restart follows.
- SYNC_POL=1, CLK_DIV=2 build -> sync pulses active-high with the same windows; p_tick every 2 clks.
- With VGA_FRAME_CNT_EN, run 257 frames -> frame_cnt increments at each wrap, reads 1 after wrap 257 (255->0 rollover seen).
